// File: rtl/adc_sample_ctrl.sv
// ADC sample controller: periodic comparator strobe, settle wait, thermometer
// latch, encoder capture with bubble flag, and a one-deep output register with
// valid/ready handshake and a sticky overrun flag.
module adc_sample_ctrl #(
    parameter int unsigned N      = 256,
    parameter int unsigned SETTLE = 4,
    parameter int unsigned PW     = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [PW-1:0] period,
    output logic          cmp_sample,
    input  logic [0:N-2]  therm_in,
    output logic [0:N-2]  therm_q,
    input  logic [7:0]    code_in,
    output logic [7:0]    out_code,
    output logic          out_bubble,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          overrun,
    input  logic          clr_ovr
);

    localparam int unsigned P_MIN = SETTLE + 4;
    localparam int unsigned CW    = 4;

    typedef enum logic [2:0] {
        IDLE,
        SAMPLE,
        WAIT,
        CONV,
        DONE
    } state_t;

    state_t          state;
    logic [PW-1:0]   count;
    logic [PW-1:0]   p_eff;
    logic            tick;
    logic [CW-1:0]   wait_cnt;
    logic [7:0]      conv_code;
    logic            conv_bubble;
    logic            bubble;

    // Effective period is clamped so a full sequence always fits between ticks
    always_comb begin
        p_eff = (period < PW'(P_MIN)) ? PW'(P_MIN) : period;
        tick  = en && (count == (p_eff - PW'(1)));
    end

    // Period counter: free-runs 0..P-1 while enabled, parked at 0 otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (!en || tick) begin
            count <= '0;
        end else begin
            count <= count + PW'(1);
        end
    end

    // Bubble: a zero level sitting below a one level in the latched word
    always_comb begin
        bubble = 1'b0;
        for (int unsigned k = 0; k < N - 2; k++) begin
            if (!therm_q[k] && therm_q[k+1]) begin
                bubble = 1'b1;
            end
        end
    end

    // Sequencing FSM with registered strobe, latch, capture and output stage
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            therm_q     <= '1;
            conv_code   <= '0;
            conv_bubble <= 1'b0;
            out_code    <= '0;
            out_bubble  <= 1'b0;
            out_valid   <= 1'b0;
            overrun     <= 1'b0;
            cmp_sample  <= 1'b0;
        end else begin
            cmp_sample <= 1'b0;
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (clr_ovr) begin
                overrun <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (tick) begin
                        state      <= SAMPLE;
                        cmp_sample <= 1'b1;
                    end
                end
                SAMPLE: begin
                    state    <= WAIT;
                    wait_cnt <= '0;
                end
                WAIT: begin
                    if (wait_cnt == CW'(SETTLE - 1)) begin
                        therm_q <= therm_in;
                        state   <= CONV;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                CONV: begin
                    conv_code   <= code_in;
                    conv_bubble <= bubble;
                    state       <= DONE;
                end
                DONE: begin
                    // A pending unaccepted sample wins; the new one is dropped
                    if (!out_valid || out_ready) begin
                        out_code   <= conv_code;
                        out_bubble <= conv_bubble;
                        out_valid  <= 1'b1;
                    end else begin
                        overrun <= 1'b1;
                    end
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adc_sample_ctrl.sv
// Directed bench for adc_sample_ctrl with a behavioural encoder on therm_q.
module tb_adc_sample_ctrl;

    localparam int TW = 255;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b0;
    logic [15:0]   period = 16'd20;
    logic          cmp_sample;
    logic [0:TW-1] therm_in = '0;
    logic [0:TW-1] therm_q;
    logic [7:0]    code_in;
    logic [7:0]    out_code;
    logic          out_bubble;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          overrun;
    logic          clr_ovr = 1'b0;

    int errors = 0;
    int checks = 0;
    int zc;

    adc_sample_ctrl #(.N(256), .SETTLE(4), .PW(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .period     (period),
        .cmp_sample (cmp_sample),
        .therm_in   (therm_in),
        .therm_q    (therm_q),
        .code_in    (code_in),
        .out_code   (out_code),
        .out_bubble (out_bubble),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .overrun    (overrun),
        .clr_ovr    (clr_ovr)
    );

    always #5 clk = ~clk;

    // Encoder model: code is the number of zero levels in the latched word
    always_comb begin
        zc = 0;
        for (int i = 0; i < TW; i++) begin
            if (!therm_q[i]) zc++;
        end
        code_in = 8'(zc);
    end

    function automatic logic [0:TW-1] therm_of(input int ones);
        logic [0:TW-1] v;
        for (int i = 0; i < TW; i++) v[i] = (i < ones);
        return v;
    endfunction

    task automatic step(input int k);
        repeat (k) @(negedge clk);
    endtask

    // Returns negedges until cmp_sample is seen, or -1 after 200 cycles
    task automatic wait_cmp(output int n);
        n = -1;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (cmp_sample) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic do_reset(input logic [15:0] p, input logic e);
        @(negedge clk);
        rst = 1'b1; en = 1'b0; clr_ovr = 1'b0; out_ready = 1'b0;
        step(2);
        period = p; en = e; rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; en = 1'b1;
        step(2);
        checks++; if (cmp_sample !== 1'b0) begin errors++; $display("FAIL reset_cmp: got %b expected 0", cmp_sample); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
        checks++; if (out_code !== 8'd0) begin errors++; $display("FAIL reset_code: got %0d expected 0", out_code); end
        checks++; if (out_bubble !== 1'b0) begin errors++; $display("FAIL reset_bubble: got %b expected 0", out_bubble); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
        checks++; if (therm_q !== {TW{1'b1}}) begin errors++; $display("FAIL reset_therm_q: got %h expected all ones", therm_q); end
    endtask

    task automatic test_basic();
        int n;
        therm_in = therm_of(155);
        do_reset(16'd20, 1'b1);
        out_ready = 1'b1;
        wait_cmp(n);
        checks++; if (n !== 20) begin errors++; $display("FAIL basic_first_cmp: got %0d expected 20", n); end
        step(1);
        checks++; if (cmp_sample !== 1'b0) begin errors++; $display("FAIL basic_cmp_width: got %b expected 0", cmp_sample); end
        step(3);
        checks++; if (therm_q !== {TW{1'b1}}) begin errors++; $display("FAIL basic_therm_early: got %h expected all ones", therm_q); end
        step(1);
        checks++; if (therm_q !== therm_of(155)) begin errors++; $display("FAIL basic_therm_latch: got %h expected %h", therm_q, therm_of(155)); end
        step(1);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_early: got %b expected 0", out_valid); end
        step(1);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b expected 1", out_valid); end
        checks++; if (out_code !== 8'd100) begin errors++; $display("FAIL basic_code: got %0d expected 100", out_code); end
        checks++; if (out_bubble !== 1'b0) begin errors++; $display("FAIL basic_bubble: got %b expected 0", out_bubble); end
        step(1);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_handshake: got %b expected 0", out_valid); end
        wait_cmp(n);
        checks++; if (n !== 12) begin errors++; $display("FAIL basic_period: got %0d expected 12", n); end
    endtask

    task automatic test_clamp();
        int n;
        int highs;
        therm_in = therm_of(155);
        do_reset(16'd3, 1'b1);
        out_ready = 1'b1;
        wait_cmp(n);
        checks++; if (n !== 8) begin errors++; $display("FAIL clamp_first_cmp: got %0d expected 8", n); end
        highs = 0;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            if (cmp_sample) highs++;
        end
        checks++; if (highs !== 3) begin errors++; $display("FAIL clamp_strobes: got %0d expected 3", highs); end
        checks++; if (cmp_sample !== 1'b1) begin errors++; $display("FAIL clamp_spacing: got %b expected 1", cmp_sample); end
    endtask

    task automatic test_bubble();
        int n;
        logic [0:TW-1] tv;
        tv = therm_of(155);
        tv[50] = 1'b0;
        therm_in = tv;
        do_reset(16'd20, 1'b1);
        out_ready = 1'b1;
        wait_cmp(n);
        step(7);
        checks++; if (out_bubble !== 1'b1) begin errors++; $display("FAIL bubble_flag: got %b expected 1", out_bubble); end
        checks++; if (out_code !== 8'd101) begin errors++; $display("FAIL bubble_code: got %0d expected 101", out_code); end
    endtask

    task automatic test_overrun();
        int n;
        therm_in = therm_of(155);
        do_reset(16'd10, 1'b1);
        wait_cmp(n);
        step(7);
        checks++; if (out_valid !== 1'b1 || out_code !== 8'd100) begin errors++; $display("FAIL ovr_first: got valid=%b code=%0d expected 1/100", out_valid, out_code); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_none: got %b expected 0", overrun); end
        therm_in = therm_of(200);
        wait_cmp(n);
        step(7);
        checks++; if (out_code !== 8'd100) begin errors++; $display("FAIL ovr_held: got %0d expected 100", out_code); end
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_set: got %b expected 1", overrun); end
        clr_ovr = 1'b1;
        step(1);
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear: got %b expected 0", overrun); end
        wait_cmp(n);
        step(7);
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_clr_collide: got %b expected 1", overrun); end
        checks++; if (out_code !== 8'd100 || out_valid !== 1'b1) begin errors++; $display("FAIL ovr_held2: got valid=%b code=%0d expected 1/100", out_valid, out_code); end
        clr_ovr = 1'b0;
    endtask

    task automatic test_back_to_back();
        int n;
        therm_in = therm_of(155);
        do_reset(16'd10, 1'b1);
        wait_cmp(n);
        step(7);
        checks++; if (out_code !== 8'd100) begin errors++; $display("FAIL b2b_first: got %0d expected 100", out_code); end
        therm_in = therm_of(200);
        wait_cmp(n);
        step(6);
        checks++; if (out_code !== 8'd100 || out_valid !== 1'b1) begin errors++; $display("FAIL b2b_hold: got valid=%b code=%0d expected 1/100", out_valid, out_code); end
        out_ready = 1'b1;
        step(1);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid: got %b expected 1", out_valid); end
        checks++; if (out_code !== 8'd55) begin errors++; $display("FAIL b2b_code: got %0d expected 55", out_code); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL b2b_overrun: got %b expected 0", overrun); end
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        int n;
        therm_in = therm_of(155);
        do_reset(16'd20, 1'b1);
        wait_cmp(n);
        step(7);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rmid_pre_valid: got %b expected 1", out_valid); end
        wait_cmp(n);
        step(2);
        rst = 1'b1;
        step(1);
        checks++; if (out_valid !== 1'b0 || out_code !== 8'd0) begin errors++; $display("FAIL rmid_out: got valid=%b code=%0d expected 0/0", out_valid, out_code); end
        checks++; if (therm_q !== {TW{1'b1}}) begin errors++; $display("FAIL rmid_therm_q: got %h expected all ones", therm_q); end
        checks++; if (cmp_sample !== 1'b0 || overrun !== 1'b0) begin errors++; $display("FAIL rmid_flags: got cmp=%b ovr=%b expected 0/0", cmp_sample, overrun); end
        rst = 1'b0;
        wait_cmp(n);
        checks++; if (n !== 20) begin errors++; $display("FAIL rmid_restart: got %0d expected 20", n); end
    endtask

    task automatic test_en_drop();
        int n;
        int highs;
        therm_in = therm_of(155);
        do_reset(16'd20, 1'b1);
        out_ready = 1'b1;
        wait_cmp(n);
        en = 1'b0;
        step(7);
        checks++; if (out_valid !== 1'b1 || out_code !== 8'd100) begin errors++; $display("FAIL endrop_complete: got valid=%b code=%0d expected 1/100", out_valid, out_code); end
        highs = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (cmp_sample) highs++;
        end
        checks++; if (highs !== 0) begin errors++; $display("FAIL endrop_idle: got %0d strobes expected 0", highs); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_clamp();
        test_bubble();
        test_overrun();
        test_back_to_back();
        test_reset_mid();
        test_en_drop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
